tt_um_akaur014_nand_bist: RTL and testbench
===========================================

// Module: tt_um_akaur014_nand_bist
// PURPOSE
// - On-chip stimulus/response engine for the NAND array: generates pseudo-random operand pairs
//   internally, applies them to an 8-bit structural NAND bank, and checks each result against
//   a behavioural ~(a&b) model.
// - Folds every result into a MISR signature and reports pass/fail plus the signature on uo_out.
// - The silicon-side counterpart of the cocotb bench: the chip drives and checks itself.
// - Standard Tiny Tapeout user-project top.
// PARAMETERS
// - VEC_BLOCK  16     vectors per step of run-length select; run length N = VEC_BLOCK*(ui_in[7:4]+1)
// - MISR_INIT  8'hFF  MISR value loaded at each start
// PORTS
// - clk      in   1  clock; all state on rising edge
// - rst_n    in   1  asynchronous active-low reset
// - ena      in   1  design selected; low = all state holds (no advance)
// - ui_in    in   8  [0] start; [1] fault inject (FAULT_INJECT_EN only); [2] view select;
//                    [3] unused; [7:4] run-length select
// - uo_out   out  8  view 0: {busy, done, pass, err_sat, mm_cnt[3:0]}; view 1: misr[7:0]
// - uio_in   in   8  LFSR seed byte, sampled on start
// - uio_out  out  8  constant 8'h00
// - uio_oe   out  8  constant 8'h00 (all uio are inputs)
// BEHAVIOUR
// Reset (rst_n low, async)
// - state=IDLE; lfsr=0; misr=0; cnt=0; mm_cnt=0; err_sat=0; done=0; start_q=0.
// - uo_out=8'h00; uio_out=uio_oe=8'h00.
// Start detection
// - start_q <= ui_in[0] every enabled cycle.
// - start = ui_in[0] & ~start_q (rising edge, 1 cycle).
// - Honoured only in IDLE or DONE; ignored in RUN.
// On start (next cycle)
// - state=RUN; lfsr={uio_in, ~uio_in} (never zero); misr=MISR_INIT.
// - cnt=0; mm_cnt=0; err_sat=0; done=0.
// - N latched from ui_in[7:4] at start; later changes have no effect.
// RUN, per cycle with ena=1
// - a=lfsr[7:0], b=lfsr[15:8].
// - dut_r from 8 structural NAND cells; ref_r = ~(a&b).
// - mismatch = (dut_r != ref_r); mm_cnt += mismatch.
// - mm_cnt saturates at 4'hF; reaching saturation sets err_sat.
// - misr <= {misr[6:0], misr[7]^misr[5]^misr[4]^misr[3]} ^ dut_r.
// - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
// - cnt += 1; on the vector where cnt==N-1: state=DONE, done=1.
// - Exactly N vectors processed; DONE is visible N cycles after entry to RUN.
// DONE
// - Holds misr, mm_cnt, err_sat until the next start or reset.
// Status flags
// - busy = (state==RUN).
// - pass = done & (mm_cnt==0).
// - ena=0 in any state: nothing updates (start_q included); resumes exactly where it stopped.
// - View select is combinational and may change any time without affecting state.
// - Reset mid-RUN aborts immediately to reset values; no partial result retained.
// - Counter width sized for N max = 16*VEC_BLOCK; cnt wraps never (terminates at N-1).
// CONFIGURATION
// - FAULT_INJECT_EN defined: while ui_in[1]=1, dut_r[0] is forced to 1 (stuck-at-1) before
//   compare and MISR; self-test of the checker.
// - FAULT_INJECT_EN undefined: ui_in[1] ignored; no forcing logic synthesised.
// TESTING
// - Reset then idle -> uo_out=8'h00 in both views; uio_oe=8'h00.
// - uio_in=8'h00, ui_in[7:4]=0, pulse start -> busy=1 for 16 cycles; first vector a=8'hFF,
//   b=8'h00; then uo_out view0=8'h60 (done, pass); view1 = bench MISR model.
// - ui_in[7:4]=4'hF -> exactly 256 RUN cycles; second start pulse mid-run ignored;
//   result identical to an uninterrupted run.
// - ena dropped for 10 cycles mid-run -> busy held, total enabled RUN cycles still N,
//   signature unchanged vs. a run with no gaps.
// - FAULT_INJECT_EN, ui_in[1]=1, N=16 -> mismatches on vectors with a[0]&b[0]=1; mm_cnt
//   equals model count (saturated 4'hF with err_sat=1 if >=15); pass=0.
// - rst_n low mid-run, then start again -> outputs zero during reset; rerun signature
//   matches a clean run.

Source files
------------

// File: rtl/tt_um_akaur014_nand_bist.sv
// Self-testing NAND bank: an LFSR feeds operand pairs to 8 gate-level NAND cells, each result is
// checked against ~(a&b) and folded into a MISR. Define FAULT_INJECT_EN to enable the stuck-at-1 checker self-test.
module tt_um_akaur014_nand_bist #(
  parameter int unsigned VEC_BLOCK = 16,
  parameter logic [7:0]  MISR_INIT = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned NMAX = 16 * VEC_BLOCK;
  localparam int unsigned CW   = (NMAX > 2) ? $clog2(NMAX) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [7:0]    misr_q, misr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_q, last_d;
  logic [3:0]    mm_cnt_q, mm_cnt_d;
  logic          err_sat_q, err_sat_d;
  logic          done_q, done_d;
  logic          start_q, start_d;

  logic          start;
  logic [7:0]    op_a, op_b;
  logic [7:0]    nand_raw, dut_r, ref_r;
  logic          mismatch;
  logic [3:0]    mm_next;
  logic          busy, pass;
  int unsigned   n_sel;

  assign op_a = lfsr_q[7:0];
  assign op_b = lfsr_q[15:8];

  // Gate-level cells so the bank under test stays structural, independent of the reference.
  for (genvar i = 0; i < 8; i++) begin : g_nand
    nand u_nand (nand_raw[i], op_a[i], op_b[i]);
  end

  assign ref_r = ~(op_a & op_b);

`ifdef FAULT_INJECT_EN
  assign dut_r = {nand_raw[7:1], nand_raw[0] | ui_in[1]};
  logic unused_ui;
  assign unused_ui = ui_in[3];
`else
  assign dut_r = nand_raw;
  logic unused_ui;
  assign unused_ui = ^{ui_in[3], ui_in[1]};
`endif

  assign mismatch = (dut_r != ref_r);
  assign mm_next  = (mm_cnt_q == 4'hF) ? 4'hF : mm_cnt_q + {3'b000, mismatch};
  assign start    = ui_in[0] & ~start_q;
  assign n_sel    = VEC_BLOCK * (32'(ui_in[7:4]) + 32'd1);

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    mm_cnt_d  = mm_cnt_q;
    err_sat_d = err_sat_q;
    done_d    = done_q;
    start_d   = start_q;
    if (ena) begin
      start_d = ui_in[0];
      case (state_q)
        ST_RUN: begin
          misr_d    = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]} ^ dut_r;
          lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          mm_cnt_d  = mm_next;
          err_sat_d = err_sat_q | (mm_next == 4'hF);
          // Count holds at N-1 on the final vector so it never wraps at the largest N.
          if (cnt_q == last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          if (start) begin
            state_d   = ST_RUN;
            lfsr_d    = {uio_in, ~uio_in};
            misr_d    = MISR_INIT;
            cnt_d     = '0;
            last_d    = CW'(n_sel - 32'd1);
            mm_cnt_d  = '0;
            err_sat_d = 1'b0;
            done_d    = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= '0;
      misr_q    <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      mm_cnt_q  <= '0;
      err_sat_q <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      mm_cnt_q  <= mm_cnt_d;
      err_sat_q <= err_sat_d;
      done_q    <= done_d;
      start_q   <= start_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign pass    = done_q & (mm_cnt_q == 4'h0);
  assign uo_out  = ui_in[2] ? misr_q : {busy, done_q, pass, err_sat_q, mm_cnt_q};
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_akaur014_nand_bist.sv
// Randomized self-checking bench for tt_um_akaur014_nand_bist against an arithmetic model.
module tb_tt_um_akaur014_nand_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tt_um_akaur014_nand_bist #(
    .VEC_BLOCK(16),
    .MISR_INIT(8'hFF)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  // Reference: run N vectors with plain integer arithmetic; returns raw mismatch count.
  function automatic void model(input logic [7:0] seed, input int sel, input bit fault,
                                output logic [7:0] sig, output int mm);
    int lf, a, b, r, good, fb, m;
    lf = int'(seed) * 256 + (255 - int'(seed));
    m  = 255;
    mm = 0;
    for (int v = 0; v < 16 * (sel + 1); v++) begin
      a    = lf % 256;
      b    = lf / 256;
      good = 255 - (a & b);
      r    = fault ? (good | 1) : good;
      if (r != good) mm++;
      fb = $countones(m & 8'hB8) % 2;
      m  = (((m * 2) % 256) + fb) ^ r;
      lf = ((lf * 2) % 65536) + ($countones(lf & 16'hB400) % 2);
    end
    sig = m[7:0];
  endfunction

  function automatic logic [7:0] view0_done(input int mm);
    int s;
    s = (mm > 15) ? 15 : mm;
    return {1'b0, 1'b1, mm == 0, mm >= 15, s[3:0]};
  endfunction

  function automatic bit fault_active(input logic f);
`ifdef FAULT_INJECT_EN
    return f;
`else
    return 1'b0;
`endif
  endfunction

  task automatic start_run(input logic [7:0] seed, input logic [3:0] sel);
    @(negedge clk);
    uio_in     = seed;
    ui_in[7:4] = sel;
    ui_in[0]   = 1'b1;
    @(negedge clk);
    ui_in[0]   = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (uo_out[7] && cycles < 400) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_view0 got %h want 00", uo_out); end
    ui_in[2] = 1'b1; #1;
    n_vec++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_view1 got %h want 00", uo_out); end
    n_vec++;
    if ({uio_oe, uio_out} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_uio got oe=%h out=%h want 00", uio_oe, uio_out);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ui_in[2] = 1'b0; #1;
    n_vec++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL idle_view0 got %h want 00", uo_out); end
    ui_in[2] = 1'b1; #1;
    n_vec++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL idle_view1 got %h want 00", uo_out); end
    ui_in[2] = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] sig;
    int mm, cyc;
    model(8'h00, 0, 1'b0, sig, mm);
    start_run(8'h00, 4'h0);
    wait_idle(cyc);
    n_vec++;
    if (cyc != 16) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 16", cyc); end
    repeat (5) @(negedge clk);
    n_vec++;
    if (uo_out !== 8'h60) begin n_fail++; $display("FAIL basic_view0 got %h want 60", uo_out); end
    ui_in[2] = 1'b1; #1;
    n_vec++;
    if (uo_out !== sig) begin n_fail++; $display("FAIL basic_misr got %h want %h", uo_out, sig); end
    ui_in[2] = 1'b0;
  endtask

  task automatic test_long_restart;
    logic [7:0] seed, sig;
    int mm, cyc;
    seed = 8'($urandom);
    model(seed, 15, 1'b0, sig, mm);
    start_run(seed, 4'hF);
    cyc = 0;
    while (uo_out[7] && cyc < 400) begin
      if (cyc == 100) begin
        ui_in[0]   = 1'b1;
        ui_in[7:4] = 4'h0;
        uio_in     = ~seed;
      end
      cyc++;
      @(negedge clk);
    end
    ui_in[0] = 1'b0;
    n_vec++;
    if (cyc != 256) begin n_fail++; $display("FAIL long_busy_cycles got %0d want 256", cyc); end
    n_vec++;
    if (uo_out !== view0_done(mm)) begin
      n_fail++; $display("FAIL long_view0 got %h want %h", uo_out, view0_done(mm));
    end
    ui_in[2] = 1'b1; #1;
    n_vec++;
    if (uo_out !== sig) begin n_fail++; $display("FAIL long_misr got %h want %h", uo_out, sig); end
    ui_in[2] = 1'b0;
  endtask

  task automatic test_ena_gap;
    logic [7:0] seed, sig;
    int mm, cyc, held;
    bit gapped;
    seed = 8'($urandom);
    model(seed, 2, 1'b0, sig, mm);
    start_run(seed, 4'h2);
    cyc = 0; held = 0; gapped = 0;
    while (uo_out[7] && cyc < 400) begin
      if (cyc == 7 && !gapped) begin
        ena = 1'b0;
        for (int g = 0; g < 10; g++) begin
          ui_in[2] = g[0];
          @(negedge clk);
          ui_in[2] = 1'b0; #1;
          if (uo_out[7]) held++;
        end
        ena = 1'b1;
        gapped = 1;
      end
      cyc++;
      @(negedge clk);
    end
    n_vec++;
    if (held != 10) begin n_fail++; $display("FAIL gap_busy_held got %0d want 10", held); end
    n_vec++;
    if (cyc != 48) begin n_fail++; $display("FAIL gap_enabled_cycles got %0d want 48", cyc); end
    ui_in[2] = 1'b1; #1;
    n_vec++;
    if (uo_out !== sig) begin n_fail++; $display("FAIL gap_misr got %h want %h", uo_out, sig); end
    ui_in[2] = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] seed, sig;
    logic [3:0] sel;
    int mm, cyc;
    for (int k = 0; k < 6; k++) begin
      seed     = 8'($urandom);
      sel      = 4'($urandom_range(0, 7));
      ui_in[1] = 1'($urandom);
      model(seed, int'(sel), fault_active(ui_in[1]), sig, mm);
      start_run(seed, sel);
      wait_idle(cyc);
      n_vec++;
      if (cyc != 16 * (int'(sel) + 1)) begin
        n_fail++; $display("FAIL rand%0d_cycles got %0d want %0d", k, cyc, 16 * (int'(sel) + 1));
      end
      n_vec++;
      if (uo_out !== view0_done(mm)) begin
        n_fail++; $display("FAIL rand%0d_view0 got %h want %h", k, uo_out, view0_done(mm));
      end
      ui_in[2] = 1'b1; #1;
      n_vec++;
      if (uo_out !== sig) begin n_fail++; $display("FAIL rand%0d_misr got %h want %h", k, uo_out, sig); end
      ui_in[2] = 1'b0;
    end
    ui_in[1] = 1'b0;
  endtask

  task automatic test_fault;
    logic [7:0] seed, sig;
    int mm, cyc;
    seed     = 8'($urandom);
    ui_in[1] = 1'b1;
    model(seed, 0, fault_active(1'b1), sig, mm);
    start_run(seed, 4'h0);
    wait_idle(cyc);
    n_vec++;
    if (uo_out !== view0_done(mm)) begin
      n_fail++; $display("FAIL fault_view0 got %h want %h", uo_out, view0_done(mm));
    end
    ui_in[2] = 1'b1; #1;
    n_vec++;
    if (uo_out !== sig) begin n_fail++; $display("FAIL fault_misr got %h want %h", uo_out, sig); end
    ui_in[2] = 1'b0;
    ui_in[1] = 1'b0;
  endtask

  task automatic test_reset_midrun;
    logic [7:0] seed, sig;
    int mm, cyc;
    seed = 8'($urandom);
    model(seed, 3, 1'b0, sig, mm);
    start_run(seed, 4'h3);
    repeat (20) @(negedge clk);
    rst_n = 1'b0; #1;
    n_vec++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL midrst_view0 got %h want 00", uo_out); end
    ui_in[2] = 1'b1; #1;
    n_vec++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL midrst_view1 got %h want 00", uo_out); end
    ui_in[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_run(seed, 4'h3);
    wait_idle(cyc);
    n_vec++;
    if (cyc != 64) begin n_fail++; $display("FAIL midrst_cycles got %0d want 64", cyc); end
    ui_in[2] = 1'b1; #1;
    n_vec++;
    if (uo_out !== sig) begin n_fail++; $display("FAIL midrst_misr got %h want %h", uo_out, sig); end
    ui_in[2] = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] sig;
    int mm, cyc;
    model(8'hA5, 1, 1'b0, sig, mm);
    start_run(8'h3C, 4'h0);
    wait_idle(cyc);
    start_run(8'hA5, 4'h1);
    wait_idle(cyc);
    n_vec++;
    if (cyc != 32) begin n_fail++; $display("FAIL b2b_cycles got %0d want 32", cyc); end
    ui_in[2] = 1'b1; #1;
    n_vec++;
    if (uo_out !== sig) begin n_fail++; $display("FAIL b2b_misr got %h want %h", uo_out, sig); end
    ui_in[2] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_restart();
    test_ena_gap();
    test_random();
    test_fault();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
